// File: rtl/clock_segment7_pkg.sv
// ---------------------------------------------------------------------------
// clock_segment7_pkg
// Shared constants for the clock divider / seven-segment decoder block.
//   - Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
//   - SEG_BLANK turns every segment off.
//   - MIN_PERIOD is the smallest divider period that still yields a real
//     clock (one low cycle, one high cycle).
// ---------------------------------------------------------------------------
package clock_segment7_pkg;

  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] MIN_PERIOD = 32'd2;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Effective period: anything below the minimum is raised to it.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] div);
    return (div < MIN_PERIOD) ? MIN_PERIOD : div;
  endfunction

endpackage

// File: rtl/segment7.sv
// ---------------------------------------------------------------------------
// segment7
// Combinational hex digit to seven-segment decoder, active-low outputs.
// Ports:
//   num [3:0] in  - digit value
//   d   [6:0] out - segment drive, d[0]=a ... d[6]=g, 0 = segment lit
// Configuration:
//   SEG7_HEX_EN - when defined, 10..15 show A b C d E F; otherwise blank.
// ---------------------------------------------------------------------------
module segment7
  import clock_segment7_pkg::*;
(
  input  logic [3:0] num,
  output logic [6:0] d
);

  always_comb begin
    d = SEG_BLANK;
    case (num)
      4'd0:  d = SEG_0;
      4'd1:  d = SEG_1;
      4'd2:  d = SEG_2;
      4'd3:  d = SEG_3;
      4'd4:  d = SEG_4;
      4'd5:  d = SEG_5;
      4'd6:  d = SEG_6;
      4'd7:  d = SEG_7;
      4'd8:  d = SEG_8;
      4'd9:  d = SEG_9;
`ifdef SEG7_HEX_EN
      4'd10: d = SEG_A;
      4'd11: d = SEG_B;
      4'd12: d = SEG_C;
      4'd13: d = SEG_D;
      4'd14: d = SEG_E;
      4'd15: d = SEG_F;
`else
      default: d = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/clock_segment7.sv
// ---------------------------------------------------------------------------
// clock_segment7
// Programmable clock divider plus seven-segment digit decoder.
// Ports:
//   clk_in        in  - system clock, rising edge
//   rst           in  - asynchronous active-high reset
//   div     [31:0] in - divider period in clk_in cycles (values < 2 act as 2)
//   num     [3:0] in  - digit to display
//   clk_out       out - divided clock: low ceil(P/2) cycles, high floor(P/2)
//   tick          out - one-cycle pulse in the cycle clk_out rises
//   d       [6:0] out - active-low segments, combinational from num
// Configuration:
//   SEG7_HEX_EN - enables hex glyphs for 10..15 in the decoder.
// ---------------------------------------------------------------------------
module clock_segment7
  import clock_segment7_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic [31:0] div,
  input  logic [3:0]  num,
  output logic        clk_out,
  output logic        tick,
  output logic [6:0]  d
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_start;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  always_comb begin
    period     = clamp_period(div);
    high_start = period - (period >> 1);

    // Compare with >= so a period shrunk below the current count wraps at
    // once instead of running up to 2^32.
    cnt_d = (cnt_q >= period - 32'd1) ? '0 : cnt_q + 32'd1;

    // clk_out is a registered view of the current count, so it lags cnt by
    // one cycle; tick fires on the same edge that raises clk_out.
    clk_out_d = (cnt_q >= high_start);
    tick_d    = clk_out_d & ~clk_out_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

  segment7 u_segment7 (
    .num (num),
    .d   (d)
  );

endmodule

// File: tb/tb_clock_segment7.sv
module tb_clock_segment7;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] div;
  logic [3:0]  num;
  logic        clk_out;
  logic        tick;
  logic [6:0]  d;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    logic  exp_clk;
    logic  exp_tick;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [3:0] num;
    logic [6:0] exp_d;
  } dec_vec_t;

  dec_vec_t dec_tbl[16];

  clock_segment7 dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div     (div),
    .num     (num),
    .clk_out (clk_out),
    .tick    (tick),
    .d       (d)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic check_outputs_low(input string name);
    check_bit({name, "_clk_out"}, clk_out, 1'b0);
    check_bit({name, "_tick"}, tick, 1'b0);
  endtask

  // Push expectations for one edge, let the edge happen, pop and compare.
  task automatic step(input string name, input logic exp_clk, input logic exp_tick);
    exp_t e;
    exp_t got;
    e.name = name;
    e.exp_clk = exp_clk;
    e.exp_tick = exp_tick;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    got = sb_q.pop_front();
    check_bit({got.name, "_clk_out"}, clk_out, got.exp_clk);
    check_bit({got.name, "_tick"}, tick, got.exp_tick);
  endtask

  // Patterns are LSB first: bit i is the value after the (i+1)-th edge.
  task automatic run_wave(input string name, input int n,
                          input logic [15:0] clk_pat, input logic [15:0] tick_pat);
    for (int i = 0; i < n; i++)
      step($sformatf("%s_c%0d", name, i + 1), clk_pat[i], tick_pat[i]);
  endtask

  // Asserts reset away from the edge, checks it takes effect at once and
  // holds across an edge, then releases it just after an edge.
  task automatic apply_reset(input string name);
    rst = 1'b1;
    #1;
    check_outputs_low({name, "_async"});
    @(posedge clk_in);
    #1;
    check_outputs_low({name, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    div = 32'd4;
    num = 4'd0;

    dec_tbl[0]  = '{4'd0,  7'h40};
    dec_tbl[1]  = '{4'd1,  7'h79};
    dec_tbl[2]  = '{4'd2,  7'h24};
    dec_tbl[3]  = '{4'd3,  7'h30};
    dec_tbl[4]  = '{4'd4,  7'h19};
    dec_tbl[5]  = '{4'd5,  7'h12};
    dec_tbl[6]  = '{4'd6,  7'h02};
    dec_tbl[7]  = '{4'd7,  7'h78};
    dec_tbl[8]  = '{4'd8,  7'h00};
    dec_tbl[9]  = '{4'd9,  7'h10};
`ifdef SEG7_HEX_EN
    dec_tbl[10] = '{4'd10, 7'h08};
    dec_tbl[11] = '{4'd11, 7'h03};
    dec_tbl[12] = '{4'd12, 7'h46};
    dec_tbl[13] = '{4'd13, 7'h21};
    dec_tbl[14] = '{4'd14, 7'h06};
    dec_tbl[15] = '{4'd15, 7'h0E};
`else
    for (int i = 10; i < 16; i++) dec_tbl[i] = '{4'(i), 7'h7F};
`endif

    // Reset at time zero with div=4.
    #1;
    check_outputs_low("reset_t0");
    @(posedge clk_in);
    #1;
    check_outputs_low("reset_t0_held");

    // Decoder while reset is asserted: d must not depend on rst.
    for (int i = 0; i < 16; i++) begin
      num = dec_tbl[i].num;
      #1;
      n_checks++;
      if (d !== dec_tbl[i].exp_d) begin
        n_errors++;
        $display("FAIL dec_rst num=%0d: got %h expected %h", dec_tbl[i].num, d, dec_tbl[i].exp_d);
      end else begin
        $display("ok   dec_rst num=%0d: %h", dec_tbl[i].num, d);
      end
    end

    @(posedge clk_in);
    #1;
    rst = 1'b0;

    // div=4 after release: 0,0,1,1,0,0,1,1 with tick on cycles 3 and 7.
    run_wave("div4", 8, 16'b1100_1100, 16'b0100_0100);

    // Decoder while the divider runs.
    for (int i = 0; i < 16; i++) begin
      num = dec_tbl[i].num;
      #1;
      n_checks++;
      if (d !== dec_tbl[i].exp_d) begin
        n_errors++;
        $display("FAIL dec_run num=%0d: got %h expected %h", dec_tbl[i].num, d, dec_tbl[i].exp_d);
      end else begin
        $display("ok   dec_run num=%0d: %h", dec_tbl[i].num, d);
      end
    end

    // Odd period: low 3, high 2, two periods.
    div = 32'd5;
    apply_reset("rst5");
    run_wave("div5", 10, 16'b11_0001_1000, 16'b01_0000_1000);

    // Degenerate periods behave as 2.
    div = 32'd0;
    apply_reset("rst0");
    run_wave("div0", 6, 16'b10_1010, 16'b10_1010);
    div = 32'd1;
    apply_reset("rst1");
    run_wave("div1", 6, 16'b10_1010, 16'b10_1010);

    // Shrinking period: 10 -> 3 while cnt=7.
    div = 32'd10;
    apply_reset("rst10");
    run_wave("div10", 7, 16'b110_0000, 16'b010_0000);
    div = 32'd3;
    run_wave("div3", 7, 16'b100_1001, 16'b100_1000);

    // Reset in the middle of a high phase aborts the period without a tick.
    div = 32'd4;
    apply_reset("rst4b");
    run_wave("div4b", 3, 16'b100, 16'b100);
    apply_reset("rst_mid");
    run_wave("div4c", 4, 16'b1100, 16'b0100);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
